// File: rtl/accu_diff.sv
// accu_diff: recovers per-sample increments from a running sum and buffers them in a FIFO
module accu_diff #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr,
    input  logic [W-1:0]             sum_in,
    input  logic                     sum_valid,
    output logic                     sum_ready,
    output logic [W-1:0]             amt_out,
    output logic                     amt_wrap,
    output logic                     amt_first,
    output logic                     amt_valid,
    input  logic                     amt_ready,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    typedef enum logic {IDLE, RUN} state_t;
    state_t          state;
    logic [W-1:0]    prev;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [W-1:0]    mem_amt   [DEPTH];
    logic            mem_wrap  [DEPTH];
    logic            mem_first [DEPTH];
    logic            push, pop;
    assign sum_ready = !reset && !clr && (count < CW'(DEPTH));
    assign amt_valid = count != '0;
    assign push      = sum_valid && sum_ready;
    assign pop       = amt_valid && amt_ready;
    assign amt_out   = amt_valid ? mem_amt[rd_ptr]   : '0;
    assign amt_wrap  = amt_valid ? mem_wrap[rd_ptr]  : 1'b0;
    assign amt_first = amt_valid ? mem_first[rd_ptr] : 1'b0;
    // storage: difference against the previous accepted sum, wrap flag and first marker
    always_ff @(posedge clk) begin
        if (push) begin
            mem_amt[wr_ptr]   <= sum_in - prev;
            mem_wrap[wr_ptr]  <= sum_in < prev;
            mem_first[wr_ptr] <= state == IDLE;
        end
    end
    // pointers, occupancy, baseline and IDLE/RUN state; clr beats any same-cycle push or pop
    always_ff @(posedge clk or posedge reset) begin
        if (reset || clr) begin
            state  <= IDLE;
            prev   <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                prev   <= sum_in;
                state  <= RUN;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end
endmodule

// File: doc/accu_diff.md
ACCU_DIFF -- requirements
Module: accu_diff

Interface
REQ-001 Parameter W, default 32, data width of the sum and amount paths.
REQ-002 Parameter DEPTH, default 4, output FIFO entries, power of two, at least 2.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately on assertion.
REQ-005 clr  input  1  synchronous clear: flush FIFO, zero baseline, return to IDLE.
REQ-006 sum_in  input  W  running-sum sample from an accumulator.
REQ-007 sum_valid  input  1  sum_in holds a valid sample.
REQ-008 sum_ready  output  1  block accepts a sample this cycle.
REQ-009 amt_out  output  W  recovered increment (FIFO head).
REQ-010 amt_wrap  output  1  recovered increment crossed a modulo-2^W wrap (FIFO head).
REQ-011 amt_first  output  1  head entry is the first sample since reset/clr.
REQ-012 amt_valid  output  1  FIFO non-empty; head fields valid.
REQ-013 amt_ready  input  1  consumer takes the head this cycle.
REQ-014 count  output  log2(DEPTH)+1  current FIFO occupancy.

Function
REQ-015 Block is the inverse of the accumulator: amt_out(n) = sum_in(n) - prev, modulo 2^W, with prev = the last accepted sum_in.
REQ-016 Push occurs on a rising edge when sum_valid && sum_ready; pop occurs when amt_valid && amt_ready.
REQ-017 sum_ready = (count < DEPTH) && !clr, derived only from registered state and clr, never from amt_ready.
REQ-018 amt_valid = (count != 0); amt_out, amt_wrap and amt_first come straight from FIFO storage (no combinational path from sum_in).
REQ-019 Latency: sample accepted at edge N is visible on amt_out (when it is the head) immediately after edge N.
REQ-020 amt_wrap = 1 when sum_in < prev (unsigned), otherwise 0; delta is still the modulo-2^W difference.
REQ-021 FSM states: IDLE (no sample since reset/clr, prev = 0) and RUN.
REQ-022 IDLE -> RUN on the first push; that entry has amt_first = 1 and delta = sum_in - 0.
REQ-023 RUN -> IDLE only on clr or reset; in RUN, amt_first = 0 for every push.
REQ-024 prev updates to sum_in on every push and holds otherwise.
REQ-025 Simultaneous push and pop with 0 < count < DEPTH: count unchanged, FIFO order preserved.
REQ-026 Pop when empty: ignored, count stays 0.
REQ-027 Push when full is impossible because sum_ready = 0; count never exceeds DEPTH.
REQ-028 Read and write pointers wrap modulo DEPTH with no gap or duplicate.
REQ-029 clr overrides a same-cycle push and pop: next state is count = 0, prev = 0, IDLE.

Reset
REQ-030 While reset = 1, or on the edge after clr = 1: count = 0, amt_valid = 0, sum_ready = 0 during reset (1 after release), prev = 0, state = IDLE, and FIFO head fields read 0.
REQ-031 Reset asserted mid-stream discards all buffered entries; no entry is popped after release until a new push.

Verification
REQ-032 Reset, then push sums 12, 14, 18 with amt_ready = 1 -> amt_out 12 (first = 1), 2, 4; amt_wrap = 0.
REQ-033 amt_ready = 0, push 5 samples with DEPTH = 4 -> count = 4, sum_ready = 0 on the 5th; drain -> 4 entries in order, then the 5th is accepted.
REQ-034 prev = 0xFFFFFFF0, push 0x00000010 -> amt_out = 0x20, amt_wrap = 1.
REQ-035 With count = 2, push and pop in the same cycle -> count stays 2, and head advances to the next entry.
REQ-036 clr asserted with count = 3 and a same-cycle push -> count = 0, next push of 7 gives amt_out = 7 with amt_first = 1.
REQ-037 Asynchronous reset pulse between clock edges mid-stream -> amt_valid = 0 immediately; following sum 9 gives amt_out = 9 with first = 1.
